// File: rtl/vermi_bus_pkg.sv
// Shared constants and types for the VERMI bus address decoder.
// The top address byte selects the device page.
package vermi_bus_pkg;

    localparam int PAGE_WIDTH = 8;
    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_t;

    localparam logic [PAGE_WIDTH-1:0] PAGE_RAM   = 8'h00;
    localparam logic [PAGE_WIDTH-1:0] PAGE_TIMER = 8'h80;
    localparam logic [PAGE_WIDTH-1:0] PAGE_UART  = 8'h81;
    localparam logic [PAGE_WIDTH-1:0] PAGE_SPARE = 8'h82;

    localparam logic [4*PAGE_WIDTH-1:0] DEFAULT_DEV_PAGE =
        {PAGE_SPARE, PAGE_UART, PAGE_TIMER, PAGE_RAM};

    function automatic logic [PAGE_WIDTH-1:0] page_of(input logic [DATA_WIDTH-1:0] addr);
        return addr[DATA_WIDTH-1 -: PAGE_WIDTH];
    endfunction

endpackage

// File: rtl/vermi_bus_watchdog.sv
// Wait-cycle counter for an outstanding bus access; flags expiry once the
// configured number of wait cycles has elapsed. Saturates instead of wrapping.
module vermi_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES) : CNT_W'(1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // A zero count means idle; counting only runs between start and clear.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (start) begin
            count_next = CNT_W'(1);
        end else if (count_reg != '0 && count_reg != CNT_LIMIT) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count_reg == CNT_LIMIT);

endmodule

// File: rtl/vermi_bus_decoder.sv
// Single-master bus decoder: routes a request to the device whose page matches
// the top address byte, with wait-state timeout, unmapped-access fault and irq merge.
module vermi_bus_decoder
    import vermi_bus_pkg::*;
#(
    parameter int                                NUM_DEVICES       = 4,
    parameter logic [NUM_DEVICES*PAGE_WIDTH-1:0] DEV_PAGE          = DEFAULT_DEV_PAGE,
    parameter int                                TIMEOUT_CYCLES    = 255,
    parameter logic [NUM_DEVICES-1:0]            IRQ_MASK          = '1,
    parameter bit                                FAULT_ON_UNMAPPED = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m_valid,
    input  logic [31:0]               m_address,
    input  logic [3:0]                m_wstrobe,
    input  logic [31:0]               m_wdata,
    output logic [31:0]               m_rdata,
    output logic                      m_ready,
    output logic                      m_irq,
    output logic [NUM_DEVICES-1:0]    d_valid,
    output logic [31:0]               d_address,
    output logic [3:0]                d_wstrobe,
    output logic [31:0]               d_wdata,
    input  logic [NUM_DEVICES*32-1:0] d_rdata,
    input  logic [NUM_DEVICES-1:0]    d_ready,
    input  logic [NUM_DEVICES-1:0]    d_irq,
    output logic                      fault,
    output logic [31:0]               fault_address,
    input  logic                      fault_clear
);

    localparam int SEL_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

    bus_state_t        state_reg, state_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic [SEL_W-1:0]  hit_idx;
    logic [SEL_W-1:0]  sel;
    logic [NUM_DEVICES-1:0] page_match;
    logic [31:0]       dev_rdata [NUM_DEVICES];
    logic              mapped;
    logic              wd_start, wd_clear, wd_expired;
    logic              fault_event;
    logic              fault_reg;
    logic [31:0]       fault_address_reg;

    for (genvar gi = 0; gi < NUM_DEVICES; gi++) begin : g_dev
        assign page_match[gi] = (DEV_PAGE[gi*PAGE_WIDTH +: PAGE_WIDTH] == page_of(m_address));
        assign dev_rdata[gi]  = d_rdata[gi*32 +: 32];
    end

    // Scan from the top so the lowest matching index wins on duplicate pages.
    always_comb begin
        hit_idx = '0;
        for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
            if (page_match[i]) begin
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign mapped = |page_match;
    assign sel    = (state_reg == BUSY) ? sel_reg : hit_idx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        wd_start    = 1'b0;
        wd_clear    = 1'b0;
        fault_event = 1'b0;
        case (state_reg)
            IDLE: begin
                if (m_valid) begin
                    if (!mapped) begin
                        fault_event = FAULT_ON_UNMAPPED;
                    end else if (!d_ready[hit_idx]) begin
                        state_next = BUSY;
                        sel_next   = hit_idx;
                        wd_start   = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!m_valid || d_ready[sel_reg]) begin
                    state_next = IDLE;
                    wd_clear   = 1'b1;
                end else if (wd_expired) begin
                    state_next  = IDLE;
                    wd_clear    = 1'b1;
                    fault_event = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                wd_clear   = 1'b1;
            end
        endcase
    end

    // Unmapped and timed-out accesses are answered locally with zero data.
    always_comb begin
        d_valid = '0;
        m_ready = 1'b0;
        m_rdata = '0;
        if (m_valid) begin
            if (state_reg == IDLE && !mapped) begin
                m_ready = 1'b1;
            end else if (state_reg == BUSY && wd_expired && !d_ready[sel]) begin
                m_ready = 1'b1;
            end else begin
                d_valid[sel] = 1'b1;
                m_ready      = d_ready[sel];
                m_rdata      = dev_rdata[sel];
            end
        end
    end

    vermi_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .start  (wd_start),
        .clear  (wd_clear),
        .expired(wd_expired)
    );

    // A new fault takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_reg         <= 1'b0;
            fault_address_reg <= '0;
        end else if (fault_event) begin
            fault_reg         <= 1'b1;
            fault_address_reg <= m_address;
        end else if (fault_clear) begin
            fault_reg         <= 1'b0;
        end
    end

    assign fault         = fault_reg;
    assign fault_address = fault_address_reg;
    assign m_irq         = (|(d_irq & IRQ_MASK)) | fault_reg;
    assign d_address     = m_address;
    assign d_wstrobe     = m_wstrobe;
    assign d_wdata       = m_wdata;

endmodule

// File: tb/tb_vermi_bus_decoder.sv
// Self-checking bench for vermi_bus_decoder: constant vector table, directed
// multi-cycle sequences, then randomized traffic against a transaction-level model.
module tb_vermi_bus_decoder;

    localparam int ND = 4;
    localparam int TO = 4;
    localparam logic [ND-1:0] MASK = 4'b0011;
    localparam logic [ND*8-1:0] PAGES = {8'h82, 8'h81, 8'h80, 8'h00};

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              m_valid = 1'b0;
    logic [31:0]       m_address = '0;
    logic [3:0]        m_wstrobe = '0;
    logic [31:0]       m_wdata = '0;
    logic [31:0]       m_rdata;
    logic              m_ready;
    logic              m_irq;
    logic [ND-1:0]     d_valid;
    logic [31:0]       d_address;
    logic [3:0]        d_wstrobe;
    logic [31:0]       d_wdata;
    logic [ND*32-1:0]  d_rdata = '0;
    logic [ND-1:0]     d_ready = '0;
    logic [ND-1:0]     d_irq = '0;
    logic              fault;
    logic [31:0]       fault_address;
    logic              fault_clear = 1'b0;

    always #5 clk = ~clk;

    vermi_bus_decoder #(
        .NUM_DEVICES      (ND),
        .DEV_PAGE         (PAGES),
        .TIMEOUT_CYCLES   (TO),
        .IRQ_MASK         (MASK),
        .FAULT_ON_UNMAPPED(1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m_valid      (m_valid),
        .m_address    (m_address),
        .m_wstrobe    (m_wstrobe),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .m_ready      (m_ready),
        .m_irq        (m_irq),
        .d_valid      (d_valid),
        .d_address    (d_address),
        .d_wstrobe    (d_wstrobe),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ready      (d_ready),
        .d_irq        (d_irq),
        .fault        (fault),
        .fault_address(fault_address),
        .fault_clear  (fault_clear)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level model: outstanding request (device, cycles waited) plus fault record.
    bit          mdl_pending = 1'b0;
    int          mdl_dev     = 0;
    int          mdl_waited  = 0;
    bit          mdl_fault   = 1'b0;
    logic [31:0] mdl_faddr   = '0;

    typedef struct {
        logic          valid;
        logic [31:0]   addr;
        logic [ND-1:0] rdy;
        logic [ND-1:0] irq;
        logic          clr;
        logic [ND-1:0] e_dv;
        logic          e_rdy;
        logic [31:0]   e_rd;
        logic          e_irq;
        logic          e_fault;
        logic [31:0]   e_faddr;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [ND-1:0] rdy);
        m_valid   = v;
        m_address = a;
        d_ready   = rdy;
    endtask

    task automatic expect_now(input string tag, input logic [ND-1:0] dv, input logic rdy,
                              input logic [31:0] rd);
        #2;
        chk({tag, ".d_valid"}, 32'(d_valid), 32'(dv));
        chk({tag, ".m_ready"}, 32'(m_ready), 32'(rdy));
        chk({tag, ".m_rdata"}, m_rdata, rd);
        $display("%s: addr=%h d_ready=%b d_valid=%b m_ready=%b m_rdata=%h",
                 tag, m_address, d_ready, d_valid, m_ready, m_rdata);
    endtask

    function automatic int decode(input logic [31:0] a);
        logic [ND*8-1:0] pg;
        pg = PAGES;
        for (int i = 0; i < ND; i++) begin
            if (pg[8*i +: 8] == a[31:24]) return i;
        end
        return -1;
    endfunction

    // Predicts the current cycle from the model, compares, then advances the model across the edge.
    task automatic model_cycle(input int n);
        logic [ND-1:0] dv;
        logic          rdy;
        logic [31:0]   rd;
        logic          irq;
        bit            ev, nb;
        int            ndev, nwait, hit;
        #2;
        dv = '0; rdy = 1'b0; rd = '0; ev = 1'b0;
        nb = mdl_pending; ndev = mdl_dev; nwait = mdl_waited;
        hit = decode(m_address);
        if (!mdl_pending) begin
            if (m_valid) begin
                if (hit < 0) begin
                    rdy = 1'b1;
                    ev  = 1'b1;
                end else begin
                    dv[hit] = 1'b1;
                    rdy     = d_ready[hit];
                    rd      = d_rdata[32*hit +: 32];
                    if (!d_ready[hit]) begin
                        nb = 1'b1; ndev = hit; nwait = 1;
                    end
                end
            end
        end else if (!m_valid) begin
            nb = 1'b0;
        end else if (d_ready[mdl_dev]) begin
            dv[mdl_dev] = 1'b1; rdy = 1'b1; rd = d_rdata[32*mdl_dev +: 32]; nb = 1'b0;
        end else if (mdl_waited == TO) begin
            rdy = 1'b1; ev = 1'b1; nb = 1'b0;
        end else begin
            dv[mdl_dev] = 1'b1; rd = d_rdata[32*mdl_dev +: 32]; nwait = mdl_waited + 1;
        end
        irq = (|(d_irq & MASK)) | mdl_fault;
        chk("rnd.d_valid", 32'(d_valid), 32'(dv));
        chk("rnd.m_ready", 32'(m_ready), 32'(rdy));
        chk("rnd.m_rdata", m_rdata, rd);
        chk("rnd.m_irq", 32'(m_irq), 32'(irq));
        chk("rnd.fault", 32'(fault), 32'(mdl_fault));
        chk("rnd.fault_address", fault_address, mdl_faddr);
        chk("rnd.d_address", d_address, m_address);
        chk("rnd.d_wdata", d_wdata, m_wdata);
        if (rdy)
            $display("txn %0d: addr=%h dev=%0d rst_n=%b ready_seen rdata=%h fault_ev=%b",
                     n, m_address, (mdl_pending ? mdl_dev : hit), reset, rd, ev);
        @(posedge clk);
        if (!reset) begin
            mdl_pending = 1'b0; mdl_waited = 0; mdl_fault = 1'b0; mdl_faddr = '0;
        end else begin
            mdl_pending = nb;
            mdl_dev     = ndev;
            mdl_waited  = nb ? nwait : 0;
            if (ev) begin
                mdl_fault = 1'b1;
                mdl_faddr = m_address;
            end else if (fault_clear) begin
                mdl_fault = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [7:0] pg;
        d_rdata = {32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000};

        // Reset state; d_valid follows live inputs even while reset is held.
        tick;
        tick;
        chk("reset.fault", 32'(fault), 32'h0);
        chk("reset.fault_address", fault_address, 32'h0);
        drive(1'b1, 32'h8000_0000, 4'b0000);
        expect_now("reset_live", 4'b0010, 1'b0, 32'hD0D0_0001);
        tick;
        drive(1'b0, 32'h0, 4'b0000);
        reset = 1'b1;
        tick;

        //                valid addr           rdy      irq      clr   e_dv     e_rdy e_rd           e_irq e_fault e_faddr
        vt[0]  = '{1'b1, 32'h0000_0010, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 32'hD0D0_0000, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 32'h8000_0004, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 32'hD0D0_0001, 1'b0, 1'b0, 32'h0};
        vt[2]  = '{1'b1, 32'h8200_0000, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 32'hD0D0_0003, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 32'h8100_0000, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'h0,         4'b0000, 4'b1010, 1'b0, 4'b0000, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 32'h0,         4'b0000, 4'b1000, 1'b0, 4'b0000, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 32'h0,         4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0};
        vt[7]  = '{1'b1, 32'h5500_0000, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'h0,          1'b0, 1'b1, 32'h5500_0000};
        vt[8]  = '{1'b1, 32'h6600_0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'h0,          1'b1, 1'b1, 32'h6600_0000};
        vt[9]  = '{1'b0, 32'h0,         4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,          1'b1, 1'b0, 32'h6600_0000};
        vt[10] = '{1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0,          1'b0, 1'b0, 32'h6600_0000};

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].valid, vt[i].addr, vt[i].rdy);
            d_irq       = vt[i].irq;
            fault_clear = vt[i].clr;
            m_wstrobe   = 4'hF;
            m_wdata     = 32'hCAFE_0000 + 32'(i);
            expect_now($sformatf("vec%0d", i), vt[i].e_dv, vt[i].e_rdy, vt[i].e_rd);
            chk($sformatf("vec%0d.m_irq", i), 32'(m_irq), 32'(vt[i].e_irq));
            chk($sformatf("vec%0d.d_wdata", i), d_wdata, 32'hCAFE_0000 + 32'(i));
            tick;
            chk($sformatf("vec%0d.fault", i), 32'(fault), 32'(vt[i].e_fault));
            chk($sformatf("vec%0d.fault_address", i), fault_address, vt[i].e_faddr);
        end
        d_irq = '0;
        fault_clear = 1'b0;

        // Wait states with an address change mid-access: selection stays latched.
        drive(1'b1, 32'h8100_0004, 4'b0000);
        expect_now("hold_c0", 4'b0100, 1'b0, 32'hD0D0_0002);
        tick;
        expect_now("hold_c1", 4'b0100, 1'b0, 32'hD0D0_0002);
        tick;
        drive(1'b1, 32'h0000_0000, 4'b0000);
        expect_now("hold_c2", 4'b0100, 1'b0, 32'hD0D0_0002);
        tick;
        drive(1'b1, 32'h0000_0000, 4'b0100);
        expect_now("hold_c3", 4'b0100, 1'b1, 32'hD0D0_0002);
        tick;
        drive(1'b0, 32'h0, 4'b0000);
        expect_now("hold_end", 4'b0000, 1'b0, 32'h0);
        tick;

        // Device never answers: forced completion on the fourth wait cycle.
        drive(1'b1, 32'h8000_0000, 4'b0000);
        for (int c = 0; c < TO; c++) begin
            expect_now($sformatf("tmo_c%0d", c), 4'b0010, 1'b0, 32'hD0D0_0001);
            tick;
        end
        expect_now("tmo_fire", 4'b0000, 1'b1, 32'h0);
        tick;
        drive(1'b0, 32'h0, 4'b0000);
        #2;
        chk("tmo.fault", 32'(fault), 32'h1);
        chk("tmo.fault_address", fault_address, 32'h8000_0000);
        chk("tmo.m_irq", 32'(m_irq), 32'h1);
        tick;

        // Reset during a wait state abandons the access and clears the fault.
        drive(1'b1, 32'h8000_0000, 4'b0000);
        expect_now("rst_c0", 4'b0010, 1'b0, 32'hD0D0_0001);
        tick;
        expect_now("rst_c1", 4'b0010, 1'b0, 32'hD0D0_0001);
        tick;
        reset = 1'b0;
        expect_now("rst_c2", 4'b0010, 1'b0, 32'hD0D0_0001);
        tick;
        reset = 1'b1;
        drive(1'b0, 32'h8000_0000, 4'b0000);
        expect_now("rst_after", 4'b0000, 1'b0, 32'h0);
        chk("rst.fault", 32'(fault), 32'h0);
        chk("rst.fault_address", fault_address, 32'h0);
        chk("rst.m_irq", 32'(m_irq), 32'h0);
        tick;
        drive(1'b1, 32'h0000_0000, 4'b0001);
        expect_now("rst_idle", 4'b0001, 1'b1, 32'hD0D0_0000);
        tick;

        // Randomized traffic from a clean reset.
        drive(1'b0, 32'h0, 4'b0000);
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        mdl_pending = 1'b0; mdl_waited = 0; mdl_fault = 1'b0; mdl_faddr = '0;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 4))
                0: pg = 8'h00;
                1: pg = 8'h80;
                2: pg = 8'h81;
                3: pg = 8'h82;
                default: pg = 8'($urandom);
            endcase
            if ($urandom_range(0, 3) != 0 || n == 0)
                m_address = {pg, 24'($urandom)};
            m_valid     = ($urandom_range(0, 19) != 0);
            m_wstrobe   = 4'($urandom);
            m_wdata     = $urandom;
            for (int d = 0; d < ND; d++) begin
                d_ready[d] = ($urandom_range(0, 9) < 3);
                d_rdata[32*d +: 32] = $urandom;
            end
            d_irq       = 4'($urandom);
            fault_clear = ($urandom_range(0, 9) == 0);
            reset       = ($urandom_range(0, 49) != 0);
            model_cycle(n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
